alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decodes RV32 ALU control fields into an ALU operation code,
// branch condition and branch enable, held in a single valid/ready output register.
// Optional M-extension support (multi-cycle MUL/DIV occupancy, IDLE/MCYC/DONE FSM)
// is enabled by defining the macro ALU_DECODE_MEXT_EN. Without it, funct7==0000001
// decodes as a base R-type op, busy is tied low and the stage never stalls itself.
module alu_decode_stage #(
  parameter int unsigned OP_W    = 5,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [2:0]      alu_ctrl_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] alu_op,
  output logic [2:0]      branch,
  output logic            branch_en,
  output logic            busy
);

  localparam logic [2:0] CLS_ADD    = 3'b000;
  localparam logic [2:0] CLS_BRANCH = 3'b001;
  localparam logic [2:0] CLS_IMM    = 3'b010;
  localparam logic [2:0] CLS_JUMP   = 3'b011;
  localparam logic [2:0] CLS_RTYPE  = 3'b100;

  // Decoded fields for the op currently presented at the input
  logic [4:0] dec_op;
  logic [2:0] dec_br;
  logic       dec_ben;
  logic       m_bit;
  logic       dec_m;

  // Output register
  logic       out_valid_q, out_valid_d;
  logic [4:0] alu_op_q, alu_op_d;
  logic [2:0] branch_q, branch_d;
  logic       branch_en_q, branch_en_d;

  logic       busy_int;
  logic       fire_in;
  logic       fire_out;

`ifdef ALU_DECODE_MEXT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MCYC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic [3:0] lat_m1;

  assign m_bit    = (funct7 == 7'b0000001);
  assign lat_m1   = funct3[2] ? 4'(DIV_LAT - 1) : 4'(MUL_LAT - 1);
  assign busy_int = busy_q;
`else
  logic unused_funct7;

  assign m_bit         = 1'b0;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign busy_int      = 1'b0;
`endif

  assign dec_m    = m_bit && (alu_ctrl_op == CLS_RTYPE);
  assign fire_out = out_valid_q && out_ready;
  assign in_ready = !rst && !busy_int && (!out_valid_q || out_ready);
  assign fire_in  = in_valid && in_ready;

  // Combinational decode of the control class into op code and branch fields
  always_comb begin
    dec_op  = '0;
    dec_br  = '0;
    dec_ben = 1'b0;
    unique case (alu_ctrl_op)
      CLS_ADD: begin
        dec_op = '0;
      end
      CLS_BRANCH: begin
        dec_op  = 5'b01000;
        dec_br  = funct3;
        dec_ben = 1'b1;
      end
      CLS_IMM: begin
        // only shift-right immediates carry the arithmetic/logical selector
        dec_op = {1'b0, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
      end
      CLS_JUMP: begin
        dec_op  = '0;
        dec_br  = 3'b010;
        dec_ben = 1'b1;
      end
      CLS_RTYPE: begin
        dec_op = {m_bit, funct7[5], funct3};
      end
      default: begin
        dec_op  = '0;
        dec_br  = '0;
        dec_ben = 1'b0;
      end
    endcase
  end

  // Next-state logic for the output register and (optionally) the M-op FSM
  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    branch_d    = branch_q;
    branch_en_d = branch_en_q;
`ifdef ALU_DECODE_MEXT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      MCYC: begin
        if (cnt_q == 4'd0) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        // IDLE and DONE share handshake handling; DONE only differs in
        // holding a finished M result, which the output register already does
        if (fire_out) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
        if (fire_in) begin
          alu_op_d    = dec_op;
          branch_d    = dec_br;
          branch_en_d = dec_ben;
          if (dec_m) begin
            state_d     = MCYC;
            busy_d      = 1'b1;
            cnt_d       = lat_m1;
            out_valid_d = 1'b0;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
          end
        end
      end
    endcase
`else
    if (fire_out) begin
      out_valid_d = 1'b0;
    end
    if (fire_in) begin
      alu_op_d    = dec_op;
      branch_d    = dec_br;
      branch_en_d = dec_ben;
      out_valid_d = 1'b1;
    end
`endif
  end

  // State and output registers, cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      branch_q    <= '0;
      branch_en_q <= 1'b0;
`ifdef ALU_DECODE_MEXT_EN
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      branch_q    <= branch_d;
      branch_en_q <= branch_en_d;
`ifdef ALU_DECODE_MEXT_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q[OP_W-1:0];
  assign branch    = branch_q;
  assign branch_en = branch_en_q;
  assign busy      = busy_int;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: driver pushes reference-model results,
// a negedge monitor checks handshakes, occupancy timing and output fields.
module tb_alu_decode_stage;

`ifdef ALU_DECODE_MEXT_EN
  localparam bit          MEXT = 1'b1;
  localparam int unsigned TB_OP_W = 5;
`else
  localparam bit          MEXT = 1'b0;
  localparam int unsigned TB_OP_W = 4;
`endif
  localparam int unsigned TB_MUL_LAT = 4;
  localparam int unsigned TB_DIV_LAT = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [6:0]         funct7 = '0;
  logic [2:0]         funct3 = '0;
  logic [2:0]         alu_ctrl_op = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [TB_OP_W-1:0] alu_op;
  logic [2:0]         branch;
  logic               branch_en;
  logic               busy;

  alu_decode_stage #(
    .OP_W   (TB_OP_W),
    .MUL_LAT(TB_MUL_LAT),
    .DIV_LAT(TB_DIV_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct7     (funct7),
    .funct3     (funct3),
    .alu_ctrl_op(alu_ctrl_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_op     (alu_op),
    .branch     (branch),
    .branch_en  (branch_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int br;
    int ben;
    int ready;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference decode from the instruction-class rules, plus the cycle at
  // which the result must appear (M ops occupy the stage for their latency)
  function automatic exp_t model(input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [2:0] cls, input int now);
    exp_t e;
    bit   m;
    e.op = 0; e.br = 0; e.ben = 0; m = 1'b0;
    case (int'(cls))
      1: begin e.op = 8; e.br = int'(f3); e.ben = 1; end
      2: e.op = int'(f3) + ((f3 == 3'd5 && f7[5]) ? 8 : 0);
      3: begin e.br = 2; e.ben = 1; end
      4: begin
        m    = MEXT && (f7 == 7'd1);
        e.op = int'(f3) + (f7[5] ? 8 : 0) + (m ? 16 : 0);
      end
      default: ;
    endcase
    e.ready = now + (m ? (f3[2] ? int'(TB_DIV_LAT) : int'(TB_MUL_LAT)) : 0);
    return e;
  endfunction

  // Monitor: checks occupancy/handshake timing and compares the head result
  always @(negedge clk) begin
    if (!rst) begin
      bit have, exp_valid, exp_busy;
      have      = sb.size() > 0;
      exp_valid = have && (cyc >= sb[0].ready);
      exp_busy  = have && (cyc < sb[0].ready);
      chk("no_x", int'($isunknown({in_ready, out_valid, alu_op, branch, branch_en, busy})), 0);
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("busy", int'(busy), int'(exp_busy));
      chk("in_ready", int'(in_ready), int'(!have || (exp_valid && out_ready)));
      if (out_valid && have) begin
        chk("alu_op", int'(alu_op), sb[0].op);
        chk("branch", int'(branch), sb[0].br);
        chk("branch_en", int'(branch_en), sb[0].ben);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1
  task automatic step(input bit v, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [2:0] cls, input bit ordy);
    bit acc;
    in_valid    = v;
    funct7      = f7;
    funct3      = f3;
    alu_ctrl_op = cls;
    out_ready   = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) sb.push_back(model(f7, f3, cls, cyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 3'd0, 3'd0, 1'b1);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_branch", int'(branch), 0);
    chk("rst_branch_en", int'(branch_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] f7sel [4];
    f7sel[0] = 7'b0000000;
    f7sel[1] = 7'b0100000;
    f7sel[2] = 7'b0000001;
    f7sel[3] = 7'b1111111;

    // Power-on reset
    #1;
    rst = 1'b1;
    #2;
    chk("por_out_valid", int'(out_valid), 0);
    chk("por_alu_op", int'(alu_op), 0);
    chk("por_branch", int'(branch), 0);
    chk("por_branch_en", int'(branch_en), 0);
    chk("por_busy", int'(busy), 0);
    chk("por_in_ready", int'(in_ready), 0);
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed decode cases
    step(1'b1, 7'b0100000, 3'b000, 3'b100, 1'b1);  // SUB R-type
    step(1'b1, 7'b0000000, 3'b101, 3'b001, 1'b1);  // branch BGE
    step(1'b1, 7'b0000000, 3'b000, 3'b011, 1'b1);  // JAL
    step(1'b1, 7'b1111111, 3'b111, 3'b111, 1'b1);  // unused class
    step(1'b1, 7'b0100000, 3'b101, 3'b010, 1'b1);  // SRAI
    step(1'b1, 7'b0100000, 3'b001, 3'b010, 1'b1);  // SLLI with funct7[5] set
    step(1'b1, 7'b0000001, 3'b100, 3'b100, 1'b1);  // DIV
    for (int i = 0; i < 12; i++) step(1'b1, 7'b0000000, 3'b110, 3'b100, 1'b1);
    idle(2);

    // Downstream stall: result must hold, input blocked, then no-bubble resume
    step(1'b1, 7'b0000000, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 7'b0100000, 3'b000, 3'b100, 1'b0);
    step(1'b1, 7'b0100000, 3'b000, 3'b100, 1'b1);
    step(1'b1, 7'b0000000, 3'b111, 3'b010, 1'b1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] f7;
      f7 = f7sel[$urandom_range(0, 3)];
      if (f7 == 7'b1111111) f7 = 7'($urandom);
      step(($urandom_range(0, 3) != 0), f7, 3'($urandom), 3'($urandom),
           ($urandom_range(0, 9) < 7));
    end
    idle(20);

    // Reset during the third cycle of a MUL
    step(1'b1, 7'b0000001, 3'b000, 3'b100, 1'b1);
    step(1'b0, 7'd0, 3'd0, 3'd0, 1'b1);
    do_reset();
    idle(10);

    // More random traffic after reset, then drain
    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(0, 1) != 0), f7sel[$urandom_range(0, 2)], 3'($urandom),
           3'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0));
    end
    idle(20);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
